// File: rtl/main_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle main controller and the ALU control
// decoder: opcode constants, the state encoding and the Alu_op codes.
package main_ctrl_fsm_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Alu_op codes interpreted by Alu_ctrl
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // Controller states, 4-bit encoding
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_EXECUTE   = 4'd7,
        ST_ALU_WB    = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_ADDI_EXEC = 4'd11,
        ST_ADDI_WB   = 4'd12,
        ST_HALT      = 4'd13
    } state_t;

endpackage : main_ctrl_fsm_pkg

// File: rtl/main_ctrl_fsm.sv
// Multicycle main controller: Moore decode of the current state, with the
// fetch write strobes and the store completion pulse gated by mem_ready.
module main_ctrl_fsm
    import main_ctrl_fsm_pkg::*;
#(
    parameter bit ILL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PC_write,
    output logic       PC_write_cond,
    output logic       IorD,
    output logic       Mem_read,
    output logic       Mem_write,
    output logic       IR_write,
    output logic       Mem_to_reg,
    output logic       Reg_dst,
    output logic       Reg_write,
    output logic       Alu_src_a,
    output logic [1:0] Alu_src_b,
    output logic [1:0] Alu_op,
    output logic [1:0] PC_source,
    output logic       instr_done,
    output logic       illegal
);

    state_t r_state;
    state_t w_next_state;

    // State register; reset returns to IDLE immediately, independent of clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection and output decode; everything defaults to 0
    always_comb begin
        w_next_state  = r_state;
        PC_write      = 1'b0;
        PC_write_cond = 1'b0;
        IorD          = 1'b0;
        Mem_read      = 1'b0;
        Mem_write     = 1'b0;
        IR_write      = 1'b0;
        Mem_to_reg    = 1'b0;
        Reg_dst       = 1'b0;
        Reg_write     = 1'b0;
        Alu_src_a     = 1'b0;
        Alu_src_b     = 2'b00;
        Alu_op        = ALU_OP_ADD;
        PC_source     = 2'b00;
        instr_done    = 1'b0;
        illegal       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                // PC+4 computed every cycle, but only committed with the IR
                Mem_read  = 1'b1;
                Alu_src_b = 2'b01;
                IR_write  = mem_ready;
                PC_write  = mem_ready;
                if (mem_ready) w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                // Speculative branch target: PC + (sign-extended imm << 2)
                Alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     w_next_state = ST_EXECUTE;
                    OP_LW, OP_SW: w_next_state = ST_MEM_ADDR;
                    OP_BEQ:       w_next_state = ST_BRANCH;
                    OP_J:         w_next_state = ST_JUMP;
                    OP_ADDI:      w_next_state = ST_ADDI_EXEC;
                    default: begin
                        illegal      = 1'b1;
                        w_next_state = ILL_HALT ? ST_HALT : ST_FETCH;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                Alu_src_a    = 1'b1;
                Alu_src_b    = 2'b10;
                w_next_state = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            end
            ST_MEM_READ: begin
                Mem_read = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) w_next_state = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                Reg_write    = 1'b1;
                Mem_to_reg   = 1'b1;
                instr_done   = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                // The store finishes in the cycle memory accepts it
                Mem_write  = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) w_next_state = ST_FETCH;
            end
            ST_EXECUTE: begin
                Alu_src_a    = 1'b1;
                Alu_op       = ALU_OP_FUNCT;
                w_next_state = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                Reg_write    = 1'b1;
                Reg_dst      = 1'b1;
                instr_done   = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_BRANCH: begin
                Alu_src_a     = 1'b1;
                Alu_op        = ALU_OP_SUB;
                PC_write_cond = 1'b1;
                PC_source     = 2'b01;
                instr_done    = 1'b1;
                w_next_state  = ST_FETCH;
            end
            ST_JUMP: begin
                PC_write     = 1'b1;
                PC_source    = 2'b10;
                instr_done   = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_ADDI_EXEC: begin
                Alu_src_a    = 1'b1;
                Alu_src_b    = 2'b10;
                w_next_state = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                Reg_write    = 1'b1;
                instr_done   = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_HALT: begin
                // Parked until reset
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule : main_ctrl_fsm

// File: doc/main_ctrl_fsm.md
MAIN_CTRL_FSM -- requirements
Module: main_ctrl_fsm

Interface
REQ-001 Parameter ILL_HALT, default 0, meaning: 1 = illegal opcode parks FSM in HALT until reset; 0 = illegal opcode returns to FETCH.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  6  IR[31:26], stable from DECODE until the instruction completes.
REQ-005 mem_ready  input  1  memory handshake; access completes in a cycle where it is 1.
REQ-006 PC_write, PC_write_cond, IorD, Mem_read, Mem_write, IR_write  output  1 each  datapath strobes/selects.
REQ-007 Mem_to_reg, Reg_dst, Reg_write, Alu_src_a  output  1 each  datapath strobes/selects.
REQ-008 Alu_src_b, Alu_op, PC_source  output  2 each  mux selects; Alu_op feeds Alu_ctrl (00 add, 01 sub, 10 funct).
REQ-009 instr_done  output  1  one-cycle pulse on the final cycle of each legal instruction.
REQ-010 illegal  output  1  one-cycle pulse in DECODE when opcode is unsupported.

Function
REQ-011 States SHALL be IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB, HALT.
REQ-012 All outputs SHALL be Moore decodes of state, except that IR_write, PC_write in FETCH and instr_done in MEM_WRITE are gated by mem_ready.
REQ-013 IDLE: all outputs 0; next FETCH unconditionally.
REQ-014 FETCH: Mem_read=1, Alu_src_a=0, Alu_src_b=01, Alu_op=00, PC_source=00, IR_write=PC_write=mem_ready; stay while mem_ready=0, else DECODE.
REQ-015 DECODE: Alu_src_a=0, Alu_src_b=11, Alu_op=00; next by opcode: 000000 EXECUTE, 100011/101011 MEM_ADDR, 000100 BRANCH, 000010 JUMP, 001000 ADDI_EXEC, other -> illegal=1, then HALT if ILL_HALT=1 else FETCH.
REQ-016 MEM_ADDR: Alu_src_a=1, Alu_src_b=10, Alu_op=00; next MEM_READ if opcode=100011, else MEM_WRITE.
REQ-017 MEM_READ: Mem_read=1, IorD=1; stay while mem_ready=0, else MEM_WB.
REQ-018 MEM_WB: Reg_write=1, Mem_to_reg=1, Reg_dst=0, instr_done=1; next FETCH.
REQ-019 MEM_WRITE: Mem_write=1, IorD=1; stay while mem_ready=0; when mem_ready=1 instr_done=1, next FETCH.
REQ-020 EXECUTE: Alu_src_a=1, Alu_src_b=00, Alu_op=10; next ALU_WB. ALU_WB: Reg_write=1, Reg_dst=1, Mem_to_reg=0, instr_done=1; next FETCH.
REQ-021 BRANCH: Alu_src_a=1, Alu_src_b=00, Alu_op=01, PC_write_cond=1, PC_source=01, instr_done=1; next FETCH.
REQ-022 JUMP: PC_write=1, PC_source=10, instr_done=1; next FETCH.
REQ-023 ADDI_EXEC: Alu_src_a=1, Alu_src_b=10, Alu_op=00; next ADDI_WB. ADDI_WB: Reg_write=1, Reg_dst=0, Mem_to_reg=0, instr_done=1; next FETCH.
REQ-024 HALT: all outputs 0; remains until rst_n=0.
REQ-025 Every output not listed for a state SHALL be 0; Mem_read and Mem_write SHALL never both be 1.
REQ-026 Cycle counts with mem_ready=1 constantly: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.

Reset
REQ-027 rst_n=0 SHALL force state to IDLE immediately, regardless of clk, including mid-instruction or mid-wait; all outputs 0 while reset asserted.
REQ-028 After rst_n deasserts, first rising edge SHALL move IDLE->FETCH.

Structure
REQ-029 Opcode constants, state encoding (4-bit enum) and Alu_op codes SHALL live in a shared package used also by Alu_ctrl.
REQ-030 Single module; output decode in one combinational block separate from the state register; no sub-module.

Verification
REQ-031 Reset, mem_ready=1, opcode=000000 -> IDLE, FETCH, DECODE, EXECUTE (Alu_op=10), ALU_WB (Reg_write=1, Reg_dst=1, instr_done=1), FETCH.
REQ-032 opcode=100011, mem_ready low 3 cycles in MEM_READ -> MEM_READ held 4 cycles, Mem_read=IorD=1, then MEM_WB with Mem_to_reg=1.
REQ-033 opcode=000100 -> BRANCH with Alu_op=01, PC_write_cond=1, PC_source=01; FETCH next; total 3 cycles.
REQ-034 opcode=111111, ILL_HALT=0 -> illegal pulse in DECODE, FETCH next; ILL_HALT=1 -> HALT, outputs 0 until reset.
REQ-035 rst_n pulled low between clock edges during MEM_WRITE wait -> Mem_write drops to 0 immediately, state IDLE, FETCH after release.
